// File: rtl/alarm_pkg.sv
// Shared types for the alarm indicator: FSM state, BCD time layout and a field unpacker.
// The SNOOZE state exists only when ALARM_SNOOZE_EN is defined.
package alarm_pkg;

`ifdef ALARM_SNOOZE_EN
   typedef enum logic [1:0] {
      IDLE,
      RING,
      SNOOZE
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE,
      RING
   } state_t;
`endif

   localparam int MIN_L  = 0;
   localparam int MIN_H  = 4;
   localparam int HOUR_L = 8;
   localparam int HOUR_H = 12;

   typedef struct packed {
      logic [3:0] hour_h;
      logic [3:0] hour_l;
      logic [3:0] min_h;
      logic [3:0] min_l;
   } bcd_time_t;

   function automatic bcd_time_t unpack_time(input logic [15:0] raw);
      bcd_time_t t;
      t.min_l  = raw[MIN_L  +: 4];
      t.min_h  = raw[MIN_H  +: 4];
      t.hour_l = raw[HOUR_L +: 4];
      t.hour_h = raw[HOUR_H +: 4];
      return t;
   endfunction

endpackage

// File: rtl/blink_timer.sv
// LED blink timing: a BLINK_HALF-cycle prescaler feeding a toggle counter that
// flags the RING_TOGGLES-th toggle as done.
module blink_timer #(
   parameter int BLINK_HALF   = 5_000_000,
   parameter int RING_TOGGLES = 600
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic toggle,
   output logic done
);

   localparam int PW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int TW = $clog2(RING_TOGGLES);

   logic [PW-1:0] presc;
   logic [TW-1:0] tog_cnt;

   assign toggle = enable && (presc == PW'(BLINK_HALF - 1));
   // done marks the toggle that would be the last one; the caller leaves RING instead
   assign done   = toggle && (tog_cnt == TW'(RING_TOGGLES - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         presc   <= '0;
         tog_cnt <= '0;
      end else if (enable) begin
         if (toggle) begin
            presc   <= '0;
            tog_cnt <= tog_cnt + TW'(1);
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

endmodule

// File: rtl/alarm_led_ctrl.sv
// Multi-channel alarm indicator: edge-triggered match, blinking LED, timeout, stop,
// enable-drop and (with ALARM_SNOOZE_EN defined) snooze.
module alarm_led_ctrl
   import alarm_pkg::*;
#(
   parameter int  NUM_ALARMS   = 4,
   parameter int  BLINK_HALF   = 5_000_000,
   parameter int  RING_TOGGLES = 600,
   parameter int  SNOOZE_MIN   = 5,
   localparam int CH_W         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [16*NUM_ALARMS-1:0] alarm_time,
   input  logic [NUM_ALARMS-1:0]   alarm_en,
   input  logic [15:0]             cur_time,
   input  logic                    min_tick,
   input  logic                    stop_pulse,
   input  logic                    snooze_pulse,
   output logic                    led,
   output logic                    ringing,
   output logic [CH_W-1:0]         ring_id
);

   state_t                state;
   logic [NUM_ALARMS-1:0] match;
   logic [NUM_ALARMS-1:0] match_q;
   logic [NUM_ALARMS-1:0] rise;
   logic                  trigger;
   logic [CH_W-1:0]       winner;
   logic                  ring_en;
   logic                  ring_active;
   logic                  blink_toggle;
   logic                  blink_done;

`ifdef ALARM_SNOOZE_EN
   localparam int SW = $clog2(SNOOZE_MIN + 1);
   logic [SW-1:0] snz_cnt;
`else
   logic unused_snooze;
   assign unused_snooze = snooze_pulse ^ min_tick ^ (SNOOZE_MIN == 0);
`endif

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         match[i] = alarm_en[i] &&
                    (unpack_time(alarm_time[16*i +: 16]) == unpack_time(cur_time));
      end
   end

   assign rise = match & ~match_q;

   always_comb begin
      trigger = 1'b0;
      winner  = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (rise[i]) begin
            trigger = 1'b1;
            winner  = CH_W'(i);
         end
      end
   end

   assign ring_en     = alarm_en[ring_id];
   assign ring_active = (state == RING);
   assign ringing     = ring_active;

   // Counters are held at zero outside RING, so every entry into RING starts a fresh blink.
   blink_timer #(
      .BLINK_HALF  (BLINK_HALF),
      .RING_TOGGLES(RING_TOGGLES)
   ) u_blink (
      .clk   (clk),
      .rst   (rst),
      .clear (~ring_active),
      .enable(ring_active),
      .toggle(blink_toggle),
      .done  (blink_done)
   );

   // NOTE: sequential state uses non-blocking assignments only; match_q resets to all
   // ones so a time already matching at reset release produces no rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         led     <= 1'b0;
         ring_id <= '0;
         match_q <= '1;
`ifdef ALARM_SNOOZE_EN
         snz_cnt <= '0;
`endif
      end else begin
         match_q <= match;
         case (state)
            IDLE: begin
               if (trigger) begin
                  state   <= RING;
                  ring_id <= winner;
                  led     <= 1'b1;
               end
            end
            RING: begin
               if (stop_pulse || !ring_en) begin
                  state <= IDLE;
                  led   <= 1'b0;
               end
`ifdef ALARM_SNOOZE_EN
               else if (snooze_pulse) begin
                  state   <= SNOOZE;
                  snz_cnt <= SW'(SNOOZE_MIN);
                  led     <= 1'b0;
               end
`endif
               else if (blink_done) begin
                  state <= IDLE;
                  led   <= 1'b0;
               end else if (blink_toggle) begin
                  led <= ~led;
               end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
               if (stop_pulse || !ring_en) begin
                  state <= IDLE;
               end else if (min_tick) begin
                  if (snz_cnt == SW'(1)) begin
                     state <= RING;
                     led   <= 1'b1;
                  end else begin
                     snz_cnt <= snz_cnt - SW'(1);
                  end
               end
            end
`endif
            default: begin
               state <= IDLE;
               led   <= 1'b0;
            end
         endcase
      end
   end

endmodule
